// File: rtl/inc_arbiter.sv
// Two requesters share one registered +1 datapath.
// A round-robin pointer picks the winner when both requesters are valid.
module inc_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_id,
  input  logic             res_ready
);

  logic             last;
  logic             grant_id;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum;

  // On contention the requester that did not win last time goes next.
  // With only one requester valid, that requester wins.
  assign grant_id   = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign can_accept = !res_valid || res_ready;

  // Readies are forced low during reset so no operand is consumed on that edge.
  assign req0_ready = !rst && can_accept && req0_valid && !grant_id;
  assign req1_ready = !rst && can_accept && req1_valid &&  grant_id;
  assign xfer       = req0_ready || req1_ready;

  assign operand = grant_id ? req1_data : req0_data;
  assign sum     = {1'b0, operand} + {{WIDTH{1'b0}}, 1'b1};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
      last      <= 1'b1;
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_data  <= sum[WIDTH-1:0];
      res_carry <= sum[WIDTH];
      res_id    <= grant_id;
      last      <= grant_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inc_arbiter.sv
// Directed bench for inc_arbiter: stimulus pushes hand-computed results,
// a negedge monitor pops and compares each result as it is consumed.
module tb_inc_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_id;
  logic       res_ready;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  inc_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic id);
    exp_t e;
    e.data  = d;
    e.carry = c;
    e.id    = id;
    exp_q.push_back(e);
  endtask

  task automatic check_readies(input string name, input logic r0, input logic r1);
    check({name, "_req0_ready"}, req0_ready, r0);
    check({name, "_req1_ready"}, req1_ready, r1);
  endtask

  // A result is consumed at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data",  res_data,  mon_e.data);
        check("res_carry", res_carry, mon_e.carry);
        check("res_id",    res_id,    mon_e.id);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h10;
    req1_valid = 1'b1; req1_data = 8'h33;
    res_ready  = 1'b1;

    // Reset with both requesters valid
    step();
    check_readies("rst", 1'b0, 1'b0);
    step();
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data",  res_data,  8'h00);
    check("rst_res_carry", res_carry, 1'b0);
    check("rst_res_id",    res_id,    1'b0);
    check_readies("rst2", 1'b0, 1'b0);

    // First contention after reset goes to req0
    rst = 1'b0;
    #1;
    check_readies("first", 1'b1, 1'b0);
    push(8'h11, 1'b0, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    check_readies("first_r1", 1'b0, 1'b1);
    push(8'h34, 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;

    // Sustained contention alternates 0,1,0,1...
    req0_valid = 1'b1; req0_data = 8'h05;
    req1_valid = 1'b1; req1_data = 8'hA0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i % 2 == 0) begin
        check_readies("contend", 1'b1, 1'b0);
        push(8'h06, 1'b0, 1'b0);
      end else begin
        check_readies("contend", 1'b0, 1'b1);
        push(8'hA1, 1'b0, 1'b1);
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Wrap-around on all-ones, then the largest non-wrapping operand
    req1_valid = 1'b1; req1_data = 8'hFF;
    #1;
    check_readies("wrap", 1'b0, 1'b1);
    push(8'h00, 1'b1, 1'b1);
    step();
    req1_data = 8'hFE;
    #1;
    check_readies("wrap2", 1'b0, 1'b1);
    push(8'hFF, 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;

    // Backpressure: result 0x21 held for 3 cycles, req0 stalled
    req0_valid = 1'b1; req0_data = 8'h20;
    #1;
    check_readies("bp_load", 1'b1, 1'b0);
    push(8'h21, 1'b0, 1'b0);
    step();
    res_ready = 1'b0;
    req0_data = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_readies("bp_stall", 1'b0, 1'b0);
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data",  res_data,  8'h21);
      check("bp_res_id",    res_id,    1'b0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check_readies("bp_release", 1'b1, 1'b0);
    push(8'h41, 1'b0, 1'b0);
    step();
    req0_valid = 1'b0;
    check("bp_nobubble_valid", res_valid, 1'b1);
    check("bp_nobubble_data",  res_data,  8'h41);

    // Pointer hold: req1 wins, idle, then contention goes to req0
    req1_valid = 1'b1; req1_data = 8'h07;
    #1;
    check_readies("ptr_r1", 1'b0, 1'b1);
    push(8'h08, 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("ptr_idle_valid", res_valid, 1'b0);
    req0_valid = 1'b1; req0_data = 8'h50;
    req1_valid = 1'b1; req1_data = 8'h60;
    #1;
    check_readies("ptr_contend", 1'b1, 1'b0);
    push(8'h51, 1'b0, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    check_readies("ptr_next", 1'b0, 1'b1);
    push(8'h61, 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    step();
    check("mid_pre_valid", res_valid, 1'b0);

    // Reset mid-stream: pending result and pending requests are discarded
    res_ready  = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h70;
    #1;
    check_readies("mid_load", 1'b1, 1'b0);
    step();
    req0_data  = 8'h90;
    req1_valid = 1'b1; req1_data = 8'h80;
    #1;
    check("mid_pending_valid", res_valid, 1'b1);
    check_readies("mid_stall", 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_readies("mid_rst", 1'b0, 1'b0);
    step();
    check("mid_after_rst_valid", res_valid, 1'b0);
    check("mid_after_rst_data",  res_data,  8'h00);
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    check_readies("mid_contend", 1'b1, 1'b0);
    push(8'h91, 1'b0, 1'b0);
    step();
    req0_valid = 1'b0;
    #1;
    check_readies("mid_next", 1'b0, 1'b1);
    push(8'h81, 1'b0, 1'b1);
    step();
    req1_valid = 1'b0;
    step();
    step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
